// File: rtl/fb_rd_pkg.sv
// Shared types and defaults for the frame buffer read-side stream.
package fb_rd_pkg;

  localparam int unsigned FB_ADDR_W    = 19;
  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_LINES_DEF  = 480;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic sof;
    logic eol;
  } fb_pix_tag_t;

endpackage

// File: rtl/fb_rd_skid_fifo.sv
// Two-entry FIFO of {pixel, tag} that absorbs RAM read latency under backpressure.
module fb_rd_skid_fifo
  import fb_rd_pkg::*;
#(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  fb_pix_tag_t   push_tag,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output fb_pix_tag_t   head_tag,
  output logic [1:0]    occupancy
);

  logic [DW+1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop_ok;

  // A pop against an empty FIFO is ignored.
  assign pop_ok = pop && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_data, push_tag};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    head_data = mem_q[rd_ptr_q][DW+1:2];
    head_tag  = fb_pix_tag_t'(mem_q[rd_ptr_q][1:0]);
    occupancy = cnt_q;
  end

endmodule

// File: rtl/frame_buffer_rd_stream.sv
// Raster-order frame buffer reader presenting pixels as a valid/ready stream with sof/eol.
// Optional FB_RD_TEST_PATTERN_EN adds tp_sel, replacing RAM data with (x ^ y).
module frame_buffer_rd_stream
  import fb_rd_pkg::*;
#(
  parameter int unsigned DW       = 9,
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          sof_req,
`ifdef FB_RD_TEST_PATTERN_EN
  input  logic          tp_sel,
`endif
  output logic [18:0]   rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_eol
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam fb_addr_t       LAST_ADDR = fb_addr_t'(H_PIXELS * V_LINES - 1);
  localparam logic [XW-1:0]  X_LAST    = XW'(H_PIXELS - 1);

  fb_addr_t      addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          inflight_q;
  fb_pix_tag_t   inflight_tag_q, issue_tag;
  logic          rd_fire, pop, push;
  logic [2:0]    credit;
  logic [1:0]    occ;
  logic [DW-1:0] push_data, head_data;
  fb_pix_tag_t   head_tag;

  assign pop       = m_valid && m_ready;
  assign credit    = 3'(occ) + 3'(inflight_q);
  // sof_req wins over a same-cycle issue; the arriving word is dropped by the flush.
  assign rd_fire   = en && !sof_req && ((credit < 3'd2) || ((credit == 3'd2) && pop));
  assign push      = inflight_q && !sof_req;
  assign issue_tag = '{sof: (x_q == '0) && (y_q == '0), eol: (x_q == X_LAST)};

`ifdef FB_RD_TEST_PATTERN_EN
  localparam int unsigned PW = (XW > YW) ? XW : YW;
  logic [DW-1:0] pat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
    end else if (rd_fire) begin
      pat_q <= DW'(PW'(x_q) ^ PW'(y_q));
    end
  end

  assign push_data = tp_sel ? pat_q : rd_data;
`else
  assign push_data = rd_data;
`endif

  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (sof_req) begin
      addr_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (rd_fire) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        x_d    = '0;
        y_d    = '0;
      end else begin
        addr_d = addr_q + fb_addr_t'(1);
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q         <= '0;
      x_q            <= '0;
      y_q            <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= rd_fire;
      if (rd_fire) begin
        inflight_tag_q <= issue_tag;
      end
    end
  end

  fb_rd_skid_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (sof_req),
    .push      (push),
    .push_data (push_data),
    .push_tag  (inflight_tag_q),
    .pop       (pop),
    .head_data (head_data),
    .head_tag  (head_tag),
    .occupancy (occ)
  );

  always_comb begin
    rd_addr = addr_q;
    m_valid = (occ != 2'd0);
    m_data  = m_valid ? head_data : '0;
    m_sof   = m_valid && head_tag.sof;
    m_eol   = m_valid && head_tag.eol;
  end

endmodule

// File: tb/tb_frame_buffer_rd_stream.sv
// Directed bench for frame_buffer_rd_stream; uses an 8-line frame so full frames stay short.
module tb_frame_buffer_rd_stream;

  localparam int H     = 640;
  localparam int V     = 8;
  localparam int FRAME = H * V;
  localparam int LAST  = FRAME - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en = 1'b0, sof_req = 1'b0, m_ready = 1'b0, tp_sel = 1'b0;
  logic [18:0] rd_addr;
  logic [8:0]  rd_data = '0;
  logic [8:0]  m_data;
  logic        m_valid, m_sof, m_eol;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_buffer_rd_stream #(
    .DW       (9),
    .H_PIXELS (H),
    .V_LINES  (V)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .sof_req (sof_req),
`ifdef FB_RD_TEST_PATTERN_EN
    .tp_sel  (tp_sel),
`endif
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sof   (m_sof),
    .m_eol   (m_eol)
  );

  // RAM model: data = addr[8:0], one clock of read latency.
  always @(posedge clk) rd_data <= rd_addr[8:0];

  // Stream monitor: expected pixel index, hold checks, frame statistics.
  int          exp_idx = 0, pop_cnt = 0, sof_cnt = 0, eol_cnt = 0, since = 0, last_gap = 0;
  int          seq_errs = 0, hold_errs = 0, addr_bad = 0, eol_idx0 = -1, eol_idx1 = -1;
  logic        wrap_seen = 1'b0, prev_stall = 1'b0, prev_sof = 1'b0, prev_eol = 1'b0;
  logic [8:0]  prev_d = '0, cap_35 = '0, cap_last = '0;
  logic [18:0] prev_addr = '0;

  function automatic logic [8:0] exp_pix(input int idx);
    int x, y;
    x = idx % H;
    y = idx / H;
    if (tp_sel) return 9'(x ^ y);
    return 9'(idx);
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_idx    = 0;
      since      = 0;
      prev_stall = 1'b0;
      prev_addr  = '0;
    end else begin
      if (rd_addr == 19'(FRAME)) addr_bad++;
      if (prev_addr == 19'(LAST) && rd_addr == '0) wrap_seen = 1'b1;
      prev_addr = rd_addr;
      if (prev_stall && !(m_valid && m_data == prev_d && m_sof == prev_sof && m_eol == prev_eol))
        hold_errs++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (m_data !== exp_pix(exp_idx) || m_sof !== (exp_idx == 0) ||
            m_eol !== ((exp_idx % H) == H - 1))
          seq_errs++;
        if (m_eol) begin
          eol_cnt++;
          if (eol_idx0 < 0) eol_idx0 = exp_idx;
          else if (eol_idx1 < 0) eol_idx1 = exp_idx;
        end
        if (m_sof) begin
          sof_cnt++;
          last_gap = since;
          since    = 1;
        end else begin
          since++;
        end
        if (exp_idx == 5 * H + 3) cap_35 = m_data;
        if (exp_idx == LAST) cap_last = m_data;
        exp_idx = (exp_idx == LAST) ? 0 : exp_idx + 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_sof   = m_sof;
      prev_eol   = m_eol;
      if (sof_req) begin
        exp_idx    = 0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [18:0] a, input int budget, input string tag);
    int n = 0;
    while (rd_addr !== a && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(rd_addr), 32'(a));
  endtask

  initial begin
    int p0, n;

    // Reset values.
    #1 reset_n = 1'b0;
    #2;
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_sof", 32'(m_sof), 0);
    chk("rst_eol", 32'(m_eol), 0);

    // First-valid latency after reset release.
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    en      = 1'b1;
    m_ready = 1'b1;
    step();
    chk("clk1_valid", 32'(m_valid), 0);
    chk("clk1_addr", 32'(rd_addr), 1);
    step();
    chk("clk2_valid", 32'(m_valid), 1);
    chk("clk2_sof", 32'(m_sof), 1);
    chk("clk2_data", 32'(m_data), 0);
    chk("clk2_addr", 32'(rd_addr), 2);

    // Full frame at full rate.
    n = 0;
    while (sof_cnt < 2 && n < FRAME + 100) begin
      step();
      n++;
    end
    chk("sof_count", 32'(sof_cnt), 2);
    chk("sof_gap", 32'(last_gap), 32'(FRAME));
    chk("eol_first", 32'(eol_idx0), 639);
    chk("eol_second", 32'(eol_idx1), 1279);
    chk("eol_per_frame", 32'(eol_cnt), 32'(V));
    chk("addr_wrap", 32'(wrap_seen), 1);
    chk("addr_overrun", 32'(addr_bad), 0);
    chk("seq_frame", 32'(seq_errs), 0);

    // Random backpressure.
    p0 = pop_cnt;
    repeat (2000) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    chk("bp_seq", 32'(seq_errs), 0);
    chk("bp_hold", 32'(hold_errs), 0);
    chk("bp_progress", 32'(pop_cnt - p0 > 500), 1);

    // Mid-frame asynchronous reset.
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(m_valid), 0);
    chk("async_addr", 32'(rd_addr), 0);
    chk("async_data", 32'(m_data), 0);
    repeat (2) step();
    reset_n = 1'b1;

    // en dropped at addr 100 with the consumer stalled.
    wait_addr(19'd100, 300, "reach_addr100");
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (10) step();
    chk("stall_addr", 32'(rd_addr), 100);
    chk("stall_valid", 32'(m_valid), 1);
    chk("stall_data", 32'(m_data), 98);
    p0      = pop_cnt;
    m_ready = 1'b1;
    repeat (6) step();
    chk("drain_pops", 32'(pop_cnt - p0), 2);
    chk("drain_empty", 32'(m_valid), 0);
    chk("drain_addr", 32'(rd_addr), 100);
    en = 1'b1;
    repeat (50) step();
    chk("resume_seq", 32'(seq_errs), 0);

    // sof_req at addr 5000 with a read in flight.
    wait_addr(19'd5000, 6000, "reach_addr5000");
    sof_req = 1'b1;
    step();
    sof_req = 1'b0;
    chk("sofreq_valid", 32'(m_valid), 0);
    chk("sofreq_addr", 32'(rd_addr), 0);
    step();
    chk("sofreq_c1_valid", 32'(m_valid), 0);
    step();
    chk("sofreq_c2_valid", 32'(m_valid), 1);
    chk("sofreq_c2_sof", 32'(m_sof), 1);
    chk("sofreq_c2_data", 32'(m_data), 0);
    repeat (100) step();
    chk("sofreq_seq", 32'(seq_errs), 0);

`ifdef FB_RD_TEST_PATTERN_EN
    // Test pattern: (3,5) -> 3^5 = 0x006; (639,7) -> 0x27F^0x007 = 0x278 -> 9 bits 0x078.
    sof_req = 1'b1;
    step();
    sof_req = 1'b0;
    tp_sel  = 1'b1;
    repeat (FRAME + 20) step();
    chk("tp_pix_3_5", 32'(cap_35), 32'h006);
    chk("tp_pix_last", 32'(cap_last), 32'h078);
    chk("tp_seq", 32'(seq_errs), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
